// File: rtl/esc_speed_ramp.sv
// Per-motor speed sequencer: arm/disarm state machine plus a per-frame slew limiter.
// SPEED changes only on frame boundaries so it lines up with the downstream PWM frame.
module esc_speed_ramp #(
    parameter int FRAME_W    = 21,
    parameter int STEP       = 16,
    parameter int ARM_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] target,
    input  logic        arm,
    input  logic        kill,
    output logic [10:0] SPEED,
    output logic        armed,
    output logic        frame_tick
);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMING   = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    localparam int              FCNT_W    = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(ARM_FRAMES - 1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ZERO = '0;
    localparam logic [11:0]     STEP_12   = 12'(STEP);
    localparam logic [10:0]     SPEED_ZERO = 11'd0;

    // Slew step computed in 12-bit math; the result never overshoots the target.
    function automatic logic [10:0] slew_next(input logic [10:0] cur, input logic [10:0] tgt);
        logic [11:0] cur_12;
        logic [11:0] tgt_12;
        cur_12 = {1'b0, cur};
        tgt_12 = {1'b0, tgt};
        if (tgt_12 > cur_12 + STEP_12) begin
            slew_next = 11'(cur_12 + STEP_12);
        end else if (tgt_12 + STEP_12 < cur_12) begin
            slew_next = 11'(cur_12 - STEP_12);
        end else begin
            slew_next = tgt;
        end
    endfunction

    logic [FRAME_W-1:0] frame_cnt_r;
    logic               arm_q_r;
    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [FCNT_W-1:0]  fcnt_r;
    logic [FCNT_W-1:0]  fcnt_nxt_s;
    logic [10:0]        speed_r;
    logic [10:0]        speed_nxt_s;
    logic               armed_r;
    logic               armed_nxt_s;
    logic               arm_rise_s;
    logic               frame_tick_s;
    logic               drop_s;

    assign frame_tick_s = &frame_cnt_r;
    assign arm_rise_s   = arm & ~arm_q_r;
    assign drop_s       = kill | ~arm;

    assign SPEED      = speed_r;
    assign armed      = armed_r;
    assign frame_tick = frame_tick_s;

    // Free-running frame counter shared with the PWM stage's frame period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= '0;
        end else begin
            frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end
    end

    // Arm history for rising-edge detection; a kill still consumes the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q_r <= 1'b0;
        end else begin
            arm_q_r <= arm;
        end
    end

    // Next-state logic: kill and arm-low override any frame-boundary action.
    always_comb begin
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        speed_nxt_s = speed_r;
        case (state_r)
            ST_DISARMED: begin
                speed_nxt_s = SPEED_ZERO;
                fcnt_nxt_s  = FCNT_ZERO;
                if (arm_rise_s && !kill) begin
                    state_nxt_s = ST_ARMING;
                end else begin
                    state_nxt_s = ST_DISARMED;
                end
            end
            ST_ARMING: begin
                speed_nxt_s = SPEED_ZERO;
                if (drop_s) begin
                    state_nxt_s = ST_DISARMED;
                    fcnt_nxt_s  = FCNT_ZERO;
                end else if (frame_tick_s) begin
                    if (fcnt_r == FCNT_LAST) begin
                        state_nxt_s = ST_RUN;
                        fcnt_nxt_s  = FCNT_ZERO;
                    end else begin
                        state_nxt_s = ST_ARMING;
                        fcnt_nxt_s  = fcnt_r + FCNT_ONE;
                    end
                end else begin
                    state_nxt_s = ST_ARMING;
                    fcnt_nxt_s  = fcnt_r;
                end
            end
            ST_RUN: begin
                fcnt_nxt_s = FCNT_ZERO;
                if (drop_s) begin
                    state_nxt_s = ST_DISARMED;
                    speed_nxt_s = SPEED_ZERO;
                end else if (frame_tick_s) begin
                    state_nxt_s = ST_RUN;
                    speed_nxt_s = slew_next(speed_r, target);
                end else begin
                    state_nxt_s = ST_RUN;
                    speed_nxt_s = speed_r;
                end
            end
            default: begin
                state_nxt_s = ST_DISARMED;
                fcnt_nxt_s  = FCNT_ZERO;
                speed_nxt_s = SPEED_ZERO;
            end
        endcase
        armed_nxt_s = (state_nxt_s == ST_RUN);
    end

    // State, arming frame count and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_DISARMED;
            fcnt_r  <= FCNT_ZERO;
            speed_r <= SPEED_ZERO;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
            speed_r <= speed_nxt_s;
            armed_r <= armed_nxt_s;
        end
    end

endmodule

// File: tb/tb_esc_speed_ramp.sv
// Directed bench for esc_speed_ramp with a 16-clock frame, STEP 16 and a 3-tick arm wait.
module tb_esc_speed_ramp;

    logic        clk;
    logic        rst;
    logic [10:0] target;
    logic        arm;
    logic        kill;
    logic [10:0] SPEED;
    logic        armed;
    logic        frame_tick;

    int n_cmp;
    int n_fail;

    esc_speed_ramp #(
        .FRAME_W   (4),
        .STEP      (16),
        .ARM_FRAMES(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .target    (target),
        .arm       (arm),
        .kill      (kill),
        .SPEED     (SPEED),
        .armed     (armed),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next frame-tick edge; a missing tick counts as a failure.
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!frame_tick) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles, expected one within 16", n);
        end
        @(posedge clk);
        #1;
    endtask

    // Arm right after a tick and wait out the three arming ticks.
    task automatic arm_and_wait(input string tag);
        arm = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (armed !== 1'b0 || SPEED !== 11'd0) begin
            n_fail++;
            $display("FAIL %s_arming_entry: armed=%0b SPEED=%0d, expected armed=0 SPEED=0", tag, armed, SPEED);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_tick();
            n_cmp++;
            if (armed !== (i == 3) || SPEED !== 11'd0) begin
                n_fail++;
                $display("FAIL %s_arm_tick%0d: armed=%0b SPEED=%0d, expected armed=%0b SPEED=0",
                         tag, i, armed, SPEED, (i == 3));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        n_cmp++;
        if (SPEED !== 11'd0 || armed !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: SPEED=%0d armed=%0b tick=%0b, expected 0/0/0", SPEED, armed, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (frame_tick !== (k == 15 || k == 31)) begin
                n_fail++;
                $display("FAIL tick_position edge %0d: frame_tick=%0b expected %0b", k, frame_tick, (k == 15 || k == 31));
            end
        end
    endtask

    task automatic test_arm_ramp();
        logic [10:0] exp_ramp [8];
        exp_ramp = '{11'd16, 11'd32, 11'd48, 11'd64, 11'd80, 11'd96, 11'd100, 11'd100};
        wait_tick();
        target = 11'd100;
        arm_and_wait("ramp");
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            n_cmp++;
            if (SPEED !== exp_ramp[i] || armed !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_step%0d: SPEED=%0d armed=%0b, expected SPEED=%0d armed=1", i, SPEED, armed, exp_ramp[i]);
            end
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (SPEED !== 11'd100) begin
            n_fail++;
            $display("FAIL ramp_hold: SPEED=%0d expected 100", SPEED);
        end
    endtask

    task automatic test_decel_glitch();
        target = 11'd70;
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd84) begin
            n_fail++;
            $display("FAIL decel_first: SPEED=%0d expected 84", SPEED);
        end
        repeat (3) @(negedge clk);
        target = 11'd0;
        @(negedge clk);
        n_cmp++;
        if (SPEED !== 11'd84) begin
            n_fail++;
            $display("FAIL glitch_midframe: SPEED=%0d expected 84", SPEED);
        end
        repeat (2) @(negedge clk);
        target = 11'd70;
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd70) begin
            n_fail++;
            $display("FAIL decel_second: SPEED=%0d expected 70", SPEED);
        end
    endtask

    task automatic test_saturation();
        target = 11'd2040;
        repeat (130) wait_tick();
        n_cmp++;
        if (SPEED !== 11'd2040) begin
            n_fail++;
            $display("FAIL sat_reach_2040: SPEED=%0d expected 2040", SPEED);
        end
        target = 11'd2047;
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd2047) begin
            n_fail++;
            $display("FAIL sat_top: SPEED=%0d expected 2047", SPEED);
        end
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd2047) begin
            n_fail++;
            $display("FAIL sat_top_hold: SPEED=%0d expected 2047", SPEED);
        end
        target = 11'd10;
        repeat (130) wait_tick();
        n_cmp++;
        if (SPEED !== 11'd10) begin
            n_fail++;
            $display("FAIL sat_reach_10: SPEED=%0d expected 10", SPEED);
        end
        target = 11'd0;
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd0 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_bottom: SPEED=%0d armed=%0b expected SPEED=0 armed=1", SPEED, armed);
        end
    endtask

    task automatic test_kill();
        target = 11'd100;
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd16) begin
            n_fail++;
            $display("FAIL kill_prep: SPEED=%0d expected 16", SPEED);
        end
        repeat (5) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (SPEED !== 11'd0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_latency: SPEED=%0d armed=%0b expected 0/0", SPEED, armed);
        end
        @(negedge clk);
        kill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            n_cmp++;
            if (armed !== 1'b0 || SPEED !== 11'd0) begin
                n_fail++;
                $display("FAIL kill_stays_disarmed tick%0d: armed=%0b SPEED=%0d expected 0/0", i, armed, SPEED);
            end
        end
        arm = 1'b0;
        wait_tick();
        arm_and_wait("rearm");
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd16) begin
            n_fail++;
            $display("FAIL rearm_first_step: SPEED=%0d expected 16", SPEED);
        end
    endtask

    task automatic test_disarm_and_arm_kill();
        repeat (4) @(negedge clk);
        arm = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (SPEED !== 11'd0 || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_low_latency: SPEED=%0d armed=%0b expected 0/0", SPEED, armed);
        end
        @(negedge clk);
        arm  = 1'b1;
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            n_cmp++;
            if (armed !== 1'b0) begin
                n_fail++;
                $display("FAIL arm_kill_consumed tick%0d: armed=%0b expected 0", i, armed);
            end
        end
        arm = 1'b0;
    endtask

    task automatic test_async_reset();
        wait_tick();
        target = 11'd100;
        arm_and_wait("pre_rst");
        repeat (7) wait_tick();
        n_cmp++;
        if (SPEED !== 11'd100 || armed !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst_speed: SPEED=%0d armed=%0b expected 100/1", SPEED, armed);
        end
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        arm = 1'b0;
        #1;
        n_cmp++;
        if (SPEED !== 11'd0 || armed !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: SPEED=%0d armed=%0b tick=%0b expected 0/0/0", SPEED, armed, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_tick();
            n_cmp++;
            if (armed !== 1'b0 || SPEED !== 11'd0) begin
                n_fail++;
                $display("FAIL post_rst_disarmed tick%0d: armed=%0b SPEED=%0d expected 0/0", i, armed, SPEED);
            end
        end
        arm_and_wait("post_rst");
        wait_tick();
        n_cmp++;
        if (SPEED !== 11'd16) begin
            n_fail++;
            $display("FAIL post_rst_step: SPEED=%0d expected 16", SPEED);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        target = 11'd0;
        arm    = 1'b0;
        kill   = 1'b0;
        test_reset();
        test_arm_ramp();
        test_decel_glitch();
        test_saturation();
        test_kill();
        test_disarm_and_arm_kill();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/esc_speed_ramp.md
# esc_speed_ramp

Per-motor speed sequencer feeding the ESC PWM interface stage. It gates the commanded motor speed through an arm/disarm state machine and a slew-rate limiter. It presents an 11-bit `SPEED` that changes only once per PWM frame, exactly at the frame boundary where the downstream ESC interface raises its pulse. The frame counter width matches the downstream 21-bit PWM counter, so the updates align with that stage's frame boundary.

## Interface
Parameters:
- `FRAME_W`, 21: width of the free-running frame counter. One frame is 2^FRAME_W clocks.
- `STEP`, 16: maximum `SPEED` change per frame, in LSBs.
- `ARM_FRAMES`, 50: number of frame ticks spent in ARMING before RUN.

Ports (one clock, `clk`; reset `rst` is asynchronous and active-high):
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `target`, in, 11: requested motor speed, unsigned 0..2047.
- `arm`, in, 1: level request to arm the motor.
- `kill`, in, 1: emergency stop; highest priority.
- `SPEED`, out, 11: registered speed to the ESC interface.
- `armed`, out, 1: high only in RUN.
- `frame_tick`, out, 1: one-cycle strobe marking the frame boundary.

## Operation
- **Frame counter:** `FRAME_W` bits, increments every clock and wraps.
  - `frame_tick` = (counter all ones), decoded directly from the counter register.
- **Arm edge detect:** registered `arm_q`; `arm_rise` = `arm` & !`arm_q`.
- **States:** DISARMED, ARMING, RUN.
  - DISARMED: `SPEED`=0, `armed`=0. Go to ARMING on `arm_rise` with `kill`=0. A level-high `arm` without a fresh rise never arms.
  - ARMING: `SPEED`=0, `armed`=0. Frame counter `fcnt` is cleared on entry and increments on each `frame_tick`. The tick on which `fcnt` = ARM_FRAMES-1 moves to RUN.
  - RUN: `armed`=1. `SPEED` starts at 0 and on each `frame_tick` loads the slew result.
  - ARMING or RUN go to DISARMED on `arm`=0 or `kill`=1, at the next clock edge and independent of `frame_tick`. `SPEED` is cleared on that same edge.
- **Priority per cycle:** `kill` > `arm`=0 > `frame_tick` actions.
- **Slew rule, evaluated in 12-bit unsigned math:**
  - if `target` > `SPEED`+`STEP`: `SPEED` += `STEP`
  - else if `target`+`STEP` < `SPEED`: `SPEED` -= `STEP`
  - else: `SPEED` = `target`
  - The result never exceeds `target` on approach, so it never wraps above 2047 or below 0.
- **Target sampling:** `target` is sampled only on `frame_tick` cycles. Changes between ticks have no effect.
- **Hold:** `SPEED` holds between ticks, giving one value per PWM frame.

## Timing
- **Reset values:** `SPEED`=0, `armed`=0, counter=0, so `frame_tick`=0. State=DISARMED, `fcnt`=0, `arm_q`=0.
- **Reset mid-operation:** reset asynchronously forces all of the above immediately. Nothing is remembered across reset.
- **First tick:** the first `frame_tick` occurs on the clock with counter = 2^FRAME_W-1, i.e. 2^FRAME_W-1 edges after reset release. Later ticks repeat every 2^FRAME_W clocks.
- **Update latency:** a `SPEED` update computed on a tick cycle is visible the cycle after the tick. It is stable for the whole following frame.
- **Arm latency:** `armed` rises on the edge of the ARM_FRAMES-th tick after entering ARMING. The first nonzero `SPEED` appears on the following tick.
- **Disarm latency:** `kill` or `arm`=0 produce `SPEED`=0 and `armed`=0 one clock later.
- **Arm and kill together:** `kill` wins. State stays DISARMED and the `arm_rise` is consumed, so re-arming needs `arm` low then high.
- **`arm_rise` on a tick:** entry to ARMING happens that edge. That tick does not count; `fcnt` starts at 0.

## Test plan
Run with `FRAME_W`=4 (tick every 16 clocks), `STEP`=16, `ARM_FRAMES`=3.
- **Reset:** assert `rst` and release it. Required: `SPEED`=0, `armed`=0, `frame_tick`=0 while in reset. First `frame_tick` at the 15th edge after release, then every 16.
- **Arm and ramp:** pulse `arm` high and hold, `target`=100. Required: `armed`=1 after the 3rd tick. `SPEED` on subsequent ticks is 16, 32, 48, 64, 80, 96, 100, then holds at 100.
- **Decel and mid-frame target:** in RUN at 100, set `target`=70. Required: 84 then 70 on successive ticks. A mid-frame `target` glitch to 0 that returns to 70 before the tick has no effect.
- **Saturation:** `SPEED`=2040 with `target`=2047 gives 2047, with no wrap. `SPEED`=10 with `target`=0 gives 0.
- **Kill mid-frame with `arm` held high:** `SPEED`=0 and `armed`=0 on the next clock, and the state stays DISARMED. Then drop `arm` and raise it again: ARMING restarts with a full 3-tick wait.
- **Async reset in RUN at `SPEED`=100, between clock edges:** all outputs go to 0 immediately. After release, `arm` must rise again to re-arm.
